// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive FSM; majority-samples RX_IN mid-bit, deserializes LSB-first,
// checks start glitch, parity and stop, and pulses data_valid / par_err / stp_err.
module uart_rx_ctrl #(
    parameter int PRESCALE_W = 6,
    parameter int EDGE_W     = 5,
    parameter int BIT_W      = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [EDGE_W-1:0]     edge_cnt,
    input  logic [BIT_W-1:0]      bit_cnt,
    output logic                  enable,
    output logic [7:0]            P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    localparam int CW = PRESCALE_W > EDGE_W ? PRESCALE_W : EDGE_W;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t       state_q, state_d;
    logic [7:0]   shift_q, shift_d, p_data_q, p_data_d;
    logic         par_fail_q, par_fail_d, par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic         dv_q, dv_d, pe_q, pe_d, se_q, se_d;
    logic [2:0]   s_q;
    logic [CW-1:0] edge_w, pre_w, half;
    logic         end_bit, sampled;

    assign edge_w  = CW'(edge_cnt);
    assign pre_w   = CW'(Prescale);
    assign half    = pre_w >> 1;
    assign end_bit = edge_w == pre_w - CW'(1);
    assign sampled = (s_q[0] & s_q[1]) | (s_q[0] & s_q[2]) | (s_q[1] & s_q[2]);

    assign enable     = state_q != IDLE;
    assign P_DATA     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        par_fail_d = par_fail_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        case (state_q)
            IDLE: if (!RX_IN) begin
                state_d    = START;
                par_en_d   = PAR_EN;
                par_typ_d  = PAR_TYP;
                par_fail_d = 1'b0;
            end
            START: if (end_bit) state_d = sampled ? IDLE : DATA;
            DATA: if (end_bit) begin
                shift_d = {sampled, shift_q[7:1]};
                if (bit_cnt == BIT_W'(8)) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: if (end_bit) begin
                par_fail_d = sampled != (^shift_q ^ par_typ_q);
                state_d    = STOP;
            end
            STOP: if (end_bit) begin
                state_d = IDLE;
                se_d    = ~sampled;
                pe_d    = par_fail_q;
                if (sampled && !par_fail_q) begin
                    dv_d     = 1'b1;
                    p_data_d = shift_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            p_data_q   <= '0;
            par_fail_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
            s_q        <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            par_fail_q <= par_fail_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
            s_q[0]     <= edge_w == half - CW'(1) ? RX_IN : s_q[0];
            s_q[1]     <= edge_w == half ? RX_IN : s_q[1];
            s_q[2]     <= edge_w == half + CW'(1) ? RX_IN : s_q[2];
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames through uart_rx_ctrl with a behavioural edge/bit counter.
module tb_uart_rx_ctrl;
    logic       CLK = 1'b0, RESET = 1'b1, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       enable, data_valid, par_err, stp_err;
    logic [7:0] P_DATA;
    int         cmp = 0, bad = 0;
    int         dv_n = 0, pe_n = 0, se_n = 0;
    logic [7:0] pd_hist [4];

    uart_rx_ctrl dut (
        .CLK(CLK), .RESET(RESET), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .Prescale(Prescale), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .enable(enable),
        .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    // edge/bit counter that the controller drives through enable
    always @(posedge CLK or posedge RESET) begin
        if (RESET || !enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == 5'(Prescale - 6'd1)) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else edge_cnt <= edge_cnt + 5'd1;
    end

    always @(negedge CLK) begin
        if (!RESET) begin
            if (data_valid) begin
                if (dv_n < 4) pd_hist[dv_n] = P_DATA;
                dv_n++;
            end
            if (par_err) pe_n++;
            if (stp_err) se_n++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        dv_n = 0;
        pe_n = 0;
        se_n = 0;
        for (int i = 0; i < 4; i++) pd_hist[i] = 8'hxx;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic pen, input logic pb, input logic stop);
        mk = pen ? {stop, pb, d, 1'b0} : {1'b1, stop, d, 1'b0};
    endfunction

    task automatic send(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            RX_IN = f[i];
            repeat (int'(Prescale)) tick();
        end
        RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) tick();
        cmp += 5;
        if (enable !== 1'b0) begin bad++; $display("FAIL rst_enable: got %b want 0", enable); end
        if (P_DATA !== 8'h00) begin bad++; $display("FAIL rst_pdata: got %h want 00", P_DATA); end
        if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_dv: got %b want 0", data_valid); end
        if (par_err !== 1'b0) begin bad++; $display("FAIL rst_pe: got %b want 0", par_err); end
        if (stp_err !== 1'b0) begin bad++; $display("FAIL rst_se: got %b want 0", stp_err); end
        RESET = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_8n1();
        Prescale = 6'd8; PAR_EN = 1'b0; clr();
        send(mk(8'hA5, 1'b0, 1'b0, 1'b1), 10);
        repeat (4) tick();
        cmp += 5;
        if (dv_n !== 1) begin bad++; $display("FAIL a5_dv_count: got %0d want 1", dv_n); end
        if (P_DATA !== 8'hA5) begin bad++; $display("FAIL a5_pdata: got %h want a5", P_DATA); end
        if (pe_n !== 0) begin bad++; $display("FAIL a5_pe_count: got %0d want 0", pe_n); end
        if (se_n !== 0) begin bad++; $display("FAIL a5_se_count: got %0d want 0", se_n); end
        if (enable !== 1'b0) begin bad++; $display("FAIL a5_enable_after: got %b want 0", enable); end
    endtask

    task automatic test_parity();
        Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0; clr();
        send(mk(8'h3C, 1'b1, 1'b0, 1'b1), 11);
        repeat (4) tick();
        cmp += 3;
        if (dv_n !== 1) begin bad++; $display("FAIL p3c_dv_count: got %0d want 1", dv_n); end
        if (P_DATA !== 8'h3C) begin bad++; $display("FAIL p3c_pdata: got %h want 3c", P_DATA); end
        if (pe_n !== 0) begin bad++; $display("FAIL p3c_pe_count: got %0d want 0", pe_n); end
        clr();
        send(mk(8'h3D, 1'b1, 1'b0, 1'b1), 11);
        repeat (4) tick();
        cmp += 4;
        if (pe_n !== 1) begin bad++; $display("FAIL p3d_pe_count: got %0d want 1", pe_n); end
        if (dv_n !== 0) begin bad++; $display("FAIL p3d_dv_count: got %0d want 0", dv_n); end
        if (se_n !== 0) begin bad++; $display("FAIL p3d_se_count: got %0d want 0", se_n); end
        if (P_DATA !== 8'h3C) begin bad++; $display("FAIL p3d_pdata_hold: got %h want 3c", P_DATA); end
    endtask

    task automatic test_glitch();
        Prescale = 6'd16; PAR_EN = 1'b0; clr();
        RX_IN = 1'b0;
        repeat (3) tick();
        RX_IN = 1'b1;
        repeat (13) tick();
        cmp += 3;
        if (enable !== 1'b1) begin bad++; $display("FAIL gl_enable_e15: got %b want 1", enable); end
        if (edge_cnt !== 5'd15) begin bad++; $display("FAIL gl_edge: got %0d want 15", edge_cnt); end
        if (bit_cnt !== 4'd0) begin bad++; $display("FAIL gl_bit: got %0d want 0", bit_cnt); end
        tick();
        cmp += 1;
        if (enable !== 1'b0) begin bad++; $display("FAIL gl_enable_idle: got %b want 0", enable); end
        repeat (20) tick();
        cmp += 2;
        if (dv_n + pe_n + se_n !== 0) begin bad++; $display("FAIL gl_pulses: got %0d want 0", dv_n + pe_n + se_n); end
        if (P_DATA !== 8'h3C) begin bad++; $display("FAIL gl_pdata: got %h want 3c", P_DATA); end
    endtask

    task automatic test_stop_err();
        Prescale = 6'd8; PAR_EN = 1'b0; clr();
        send(mk(8'h81, 1'b0, 1'b0, 1'b0), 10);
        repeat (4) tick();
        cmp += 3;
        if (se_n !== 1) begin bad++; $display("FAIL s81_se_count: got %0d want 1", se_n); end
        if (dv_n !== 0) begin bad++; $display("FAIL s81_dv_count: got %0d want 0", dv_n); end
        if (P_DATA !== 8'h3C) begin bad++; $display("FAIL s81_pdata_hold: got %h want 3c", P_DATA); end
        repeat (24) tick();
        clr();
        send(mk(8'h55, 1'b0, 1'b0, 1'b1), 10);
        repeat (4) tick();
        cmp += 3;
        if (dv_n !== 1) begin bad++; $display("FAIL s55_dv_count: got %0d want 1", dv_n); end
        if (P_DATA !== 8'h55) begin bad++; $display("FAIL s55_pdata: got %h want 55", P_DATA); end
        if (se_n + pe_n !== 0) begin bad++; $display("FAIL s55_errs: got %0d want 0", se_n + pe_n); end
    endtask

    task automatic test_back_to_back();
        Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1; clr();
        send(mk(8'h00, 1'b1, 1'b1, 1'b1), 11);
        send(mk(8'hFF, 1'b1, 1'b1, 1'b1), 11);
        repeat (6) tick();
        cmp += 5;
        if (dv_n !== 2) begin bad++; $display("FAIL b2b_dv_count: got %0d want 2", dv_n); end
        if (pd_hist[0] !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h want 00", pd_hist[0]); end
        if (pd_hist[1] !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h want ff", pd_hist[1]); end
        if (pe_n + se_n !== 0) begin bad++; $display("FAIL b2b_errs: got %0d want 0", pe_n + se_n); end
        if (P_DATA !== 8'hFF) begin bad++; $display("FAIL b2b_pdata: got %h want ff", P_DATA); end
    endtask

    task automatic test_mid_reset();
        logic [10:0] f;
        Prescale = 6'd8; PAR_EN = 1'b0; clr();
        f = mk(8'hF0, 1'b0, 1'b0, 1'b1);
        send(f, 5);
        RX_IN = f[5];
        repeat (4) tick();
        cmp += 1;
        if (enable !== 1'b1) begin bad++; $display("FAIL mr_enable_pre: got %b want 1", enable); end
        #1 RESET = 1'b1;
        #1;
        cmp += 5;
        if (enable !== 1'b0) begin bad++; $display("FAIL mr_enable: got %b want 0", enable); end
        if (P_DATA !== 8'h00) begin bad++; $display("FAIL mr_pdata: got %h want 00", P_DATA); end
        if (data_valid !== 1'b0) begin bad++; $display("FAIL mr_dv: got %b want 0", data_valid); end
        if (par_err !== 1'b0) begin bad++; $display("FAIL mr_pe: got %b want 0", par_err); end
        if (stp_err !== 1'b0) begin bad++; $display("FAIL mr_se: got %b want 0", stp_err); end
        RX_IN = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
        repeat (3) tick();
        clr();
        send(mk(8'h12, 1'b0, 1'b0, 1'b1), 10);
        repeat (4) tick();
        cmp += 3;
        if (dv_n !== 1) begin bad++; $display("FAIL mr12_dv_count: got %0d want 1", dv_n); end
        if (P_DATA !== 8'h12) begin bad++; $display("FAIL mr12_pdata: got %h want 12", P_DATA); end
        if (pe_n + se_n !== 0) begin bad++; $display("FAIL mr12_errs: got %0d want 0", pe_n + se_n); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_stop_err();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
